// File: rtl/hs32_bus_arb.sv
// Round-robin arbiter sharing the internal memory bus among N requesters.
// One transaction per grant, eligibility mask at arbitration, watchdog termination.
module hs32_bus_arb #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_stb,
  input  logic [N-1:0]    m_rw,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_dtw,
  output logic [N-1:0]    m_ack,
  output logic            m_err,
  output logic [DW-1:0]   m_dtr,
  input  logic [N-1:0]    eligible,
  output logic            s_stb,
  output logic            s_rw,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_dtw,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dtr,
  output logic [N-1:0]    grant,
  output logic            busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   grant_idx, last_idx, pick_idx;
  logic [WW-1:0]   wd_cnt;
  logic [N-1:0]    req;
  logic            pick_vld, gstb, wd_fire;

  assign req  = m_stb & eligible;
  assign gstb = m_stb[grant_idx];

  // Scan starts just after the previous owner, so the last winner has lowest priority.
  always_comb begin
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_idx) + k) % N);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      assign wd_fire = (state == BUSY) && gstb && !s_ack && (wd_cnt == WW'(TIMEOUT - 1));
    end else begin : g_nowd
      assign wd_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= IW'(N - 1);
      wd_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (pick_vld) grant_idx <= pick_idx;
        wd_cnt <= '0;
      end else begin
        if (state_nxt == IDLE) last_idx <= grant_idx;
        if (!s_ack) wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_stb     = 1'b0;
    s_rw      = 1'b0;
    s_addr    = '0;
    s_dtw     = '0;
    m_ack     = '0;
    m_err     = 1'b0;
    m_dtr     = s_dtr;
    grant     = '0;
    busy      = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = BUSY;
      BUSY: begin
        busy             = 1'b1;
        grant[grant_idx] = 1'b1;
        s_rw             = m_rw[grant_idx];
        s_addr           = m_addr[int'(grant_idx)*AW +: AW];
        s_dtw            = m_dtw[int'(grant_idx)*DW +: DW];
        if (!gstb) begin
          state_nxt = IDLE;
        end else if (s_ack) begin
          s_stb            = 1'b1;
          m_ack[grant_idx] = 1'b1;
          state_nxt        = IDLE;
        end else if (wd_fire) begin
          // Terminate on behalf of the silent slave; stb is withdrawn this cycle.
          m_ack[grant_idx] = 1'b1;
          m_err            = 1'b1;
          m_dtr            = DW'(32'hDEAD_BEEF);
          state_nxt        = IDLE;
        end else begin
          s_stb = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset is synchronous, so quiet the bus while it is held.
    if (rst) begin
      state_nxt = IDLE;
      s_stb     = 1'b0;
      m_ack     = '0;
      m_err     = 1'b0;
      grant     = '0;
      busy      = 1'b0;
    end
  end
endmodule

// File: tb/tb_hs32_bus_arb.sv
// Directed bench for hs32_bus_arb: expected acks are queued at issue time and
// checked by an independent monitor whenever any m_ack is seen.
module tb_hs32_bus_arb;
  localparam int N = 2, AW = 32, DW = 32, TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_stb, m_rw, m_ack, eligible, grant;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_dtw;
  logic            m_err, s_stb, s_rw, s_ack, busy;
  logic [DW-1:0]   m_dtr, s_dtw, s_dtr;
  logic [AW-1:0]   s_addr;

  hs32_bus_arb #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_stb(m_stb), .m_rw(m_rw), .m_addr(m_addr), .m_dtw(m_dtw),
    .m_ack(m_ack), .m_err(m_err), .m_dtr(m_dtr), .eligible(eligible),
    .s_stb(s_stb), .s_rw(s_rw), .s_addr(s_addr), .s_dtw(s_dtw),
    .s_ack(s_ack), .s_dtr(s_dtr), .grant(grant), .busy(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ack; logic err; logic [31:0] dtr; logic stb;
    logic [31:0] addr; logic [31:0] dtw; logic rw;
  } exp_t;

  exp_t       sb[$];
  int         pend[N];
  int         checks = 0, errors = 0;
  logic       sl_mute = 1'b0;
  int         sl_wait = 0, scnt = 0;
  logic [N-1:0] acks_q;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic [N-1:0] ack, input logic err, input logic [31:0] dtr,
                               input logic stb, input logic [31:0] addr, input logic [31:0] dtw,
                               input logic rw);
    exp_t e;
    e.ack = ack; e.err = err; e.dtr = dtr; e.stb = stb; e.addr = addr; e.dtw = dtw; e.rw = rw;
    sb.push_back(e);
  endfunction

  task automatic set_req(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d);
    m_rw[i] = rw;
    m_addr[i*AW +: AW] = a;
    m_dtw[i*DW +: DW] = d;
  endtask

  task automatic cyc();
    @(negedge clk); #3;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; m_stb = '0; pend[0] = 0; pend[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    logic ok;
    ok = 1'b0;
    repeat (200) begin
      cyc();
      if (pend[0] == 0 && pend[1] == 0 && !busy) begin ok = 1'b1; break; end
    end
    check(nm, ok, 1);
  endtask

  // Busy cycles until the first m_ack, bounded.
  task automatic busy_until_ack(output int nb);
    nb = 0;
    repeat (60) begin
      cyc();
      if (busy) nb++;
      if (m_ack != 0) break;
    end
  endtask

  // Slave: acks after sl_wait BUSY cycles; counting on busy keeps ack timing
  // independent of the stb the arbiter withdraws on a watchdog cycle.
  initial begin
    s_ack = 1'b0;
    forever begin
      @(negedge clk);
      s_ack = busy && !sl_mute && (scnt >= sl_wait);
      if (busy) scnt++; else scnt = 0;
    end
  end

  // Requesters hold stb until acked, then reissue while transactions remain.
  initial begin
    forever begin
      @(negedge clk); #2 acks_q = m_ack;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (acks_q[i] && pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) m_stb[i] = 1'b0;
        end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (m_ack != 0) begin
        if (sb.size() == 0) check("unexpected_ack", 64'(m_ack), 0);
        else begin
          e = sb.pop_front();
          check("m_ack", 64'(m_ack), 64'(e.ack));
          check("m_err", 64'(m_err), 64'(e.err));
          check("m_dtr", 64'(m_dtr), 64'(e.dtr));
          check("s_stb", 64'(s_stb), 64'(e.stb));
          check("s_addr", 64'(s_addr), 64'(e.addr));
          check("s_dtw", 64'(s_dtw), 64'(e.dtw));
          check("s_rw", 64'(s_rw), 64'(e.rw));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int nb, ni;
    logic found;
    rst = 1'b1; m_stb = '0; m_rw = '0; m_addr = '0; m_dtw = '0;
    eligible = 2'b11; s_dtr = '0; pend[0] = 0; pend[1] = 0;
    repeat (2) @(posedge clk);
    cyc();
    check("rst_s_stb", 64'(s_stb), 0);
    check("rst_m_ack", 64'(m_ack), 0);
    check("rst_m_err", 64'(m_err), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single CPU write, immediate ack
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h10, 32'h1234_5678); s_dtr = '0; sl_wait = 0;
    push(2'b01, 1'b0, 32'h0, 1'b1, 32'h10, 32'h1234_5678, 1'b1);
    pend[0] = 1; m_stb[0] = 1'b1;
    cyc(); check("t1_stb_before", 64'(s_stb), 0);
    cyc(); check("t1_stb_k1", 64'(s_stb), 1); check("t1_grant", 64'(grant), 2'b01);
    cyc(); check("t1_stb_after", 64'(s_stb), 0); check("t1_busy_after", 64'(busy), 0);
    wait_done("t1_done");

    // Contention: grants 0,1,0,1 with one idle bubble between
    do_reset();
    set_req(0, 1'b1, 32'h100, 32'hA0); set_req(1, 1'b0, 32'h200, 32'hB1);
    s_dtr = 32'h55AA_55AA;
    push(2'b01, 1'b0, 32'h55AA_55AA, 1'b1, 32'h100, 32'hA0, 1'b1);
    push(2'b10, 1'b0, 32'h55AA_55AA, 1'b1, 32'h200, 32'hB1, 1'b0);
    push(2'b01, 1'b0, 32'h55AA_55AA, 1'b1, 32'h100, 32'hA0, 1'b1);
    push(2'b10, 1'b0, 32'h55AA_55AA, 1'b1, 32'h200, 32'hB1, 1'b0);
    pend[0] = 2; pend[1] = 2; m_stb = 2'b11;
    nb = 0; ni = 0;
    repeat (40) begin
      cyc();
      if (pend[0] == 0 && pend[1] == 0) break;
      if (busy) nb++; else if (nb > 0) ni++;
    end
    check("t2_busy_cycles", 64'(nb), 4);
    check("t2_bubbles", 64'(ni), 3);
    wait_done("t2_done");

    // Eligibility: only requester 1, then mask flips mid-transaction
    do_reset();
    eligible = 2'b10; sl_wait = 2; s_dtr = '0;
    set_req(0, 1'b1, 32'h111, 32'hC0); set_req(1, 1'b1, 32'h222, 32'hD1);
    push(2'b10, 1'b0, 32'h0, 1'b1, 32'h222, 32'hD1, 1'b1);
    push(2'b10, 1'b0, 32'h0, 1'b1, 32'h222, 32'hD1, 1'b1);
    push(2'b01, 1'b0, 32'h0, 1'b1, 32'h111, 32'hC0, 1'b1);
    pend[0] = 1; pend[1] = 2; m_stb = 2'b11;
    found = 1'b0;
    repeat (40) begin
      cyc();
      if (busy && pend[1] == 1) begin found = 1'b1; break; end
    end
    check("t3_second_grant_seen", 64'(found), 1);
    check("t3_grant_owner", 64'(grant), 2'b10);
    @(posedge clk); #1 eligible = 2'b01;
    wait_done("t3_done");
    eligible = 2'b11;

    // Read with 3 wait states from requester 1
    do_reset();
    set_req(1, 1'b0, 32'h300, 32'h0); s_dtr = 32'hCAFE_F00D; sl_wait = 3;
    push(2'b10, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h300, 32'h0, 1'b0);
    pend[1] = 1; m_stb[1] = 1'b1;
    busy_until_ack(nb);
    check("t4_ack_busy_cycle", 64'(nb), 4);
    wait_done("t4_done");

    // Watchdog fires after TIMEOUT busy cycles
    do_reset();
    sl_mute = 1'b1; sl_wait = 0;
    set_req(0, 1'b1, 32'h400, 32'h77);
    push(2'b01, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h400, 32'h77, 1'b1);
    pend[0] = 1; m_stb[0] = 1'b1;
    busy_until_ack(nb);
    check("t5_wd_cycles", 64'(nb), TO);
    cyc(); check("t5_idle_after_wd", 64'(busy), 0);
    wait_done("t5_done");

    // Ack on the timeout cycle wins over the watchdog
    @(posedge clk); #1;
    sl_mute = 1'b0; sl_wait = TO - 1; s_dtr = 32'h1357_9BDF;
    set_req(0, 1'b0, 32'h404, 32'h0);
    push(2'b01, 1'b0, 32'h1357_9BDF, 1'b1, 32'h404, 32'h0, 1'b0);
    pend[0] = 1; m_stb[0] = 1'b1;
    busy_until_ack(nb);
    check("t5_late_ack_cycles", 64'(nb), TO);
    wait_done("t5b_done");

    // Abort in BUSY cycle 2
    do_reset();
    sl_mute = 1'b1; sl_wait = 0;
    set_req(0, 1'b1, 32'h500, 32'h99);
    pend[0] = 1; m_stb[0] = 1'b1;
    found = 1'b0;
    repeat (20) begin cyc(); if (busy) begin found = 1'b1; break; end end
    check("t6_granted", 64'(found), 1);
    @(posedge clk); #1 m_stb[0] = 1'b0; pend[0] = 0;
    cyc(); check("t6_stb_drop", 64'(s_stb), 0); check("t6_no_ack", 64'(m_ack), 0);
    cyc(); check("t6_idle_next", 64'(busy), 0);
    repeat (12) cyc();
    check("t6_still_idle", 64'(busy), 0);

    // Reset during BUSY drops the transaction; requester 0 wins afterwards
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h600, 32'h66);
    pend[1] = 1; m_stb[1] = 1'b1;
    found = 1'b0;
    repeat (20) begin cyc(); if (busy) begin found = 1'b1; break; end end
    check("t7_busy", 64'(found), 1);
    check("t7_grant1", 64'(grant), 2'b10);
    @(posedge clk); #1;
    rst = 1'b1; sl_mute = 1'b0; sl_wait = 0;
    set_req(0, 1'b1, 32'h610, 32'h61);
    push(2'b01, 1'b0, 32'h1357_9BDF, 1'b1, 32'h610, 32'h61, 1'b1);
    push(2'b10, 1'b0, 32'h1357_9BDF, 1'b1, 32'h600, 32'h66, 1'b1);
    pend[0] = 1; m_stb[0] = 1'b1;
    cyc();
    check("t7_rst_grant", 64'(grant), 0);
    check("t7_rst_stb", 64'(s_stb), 0);
    check("t7_rst_ack", 64'(m_ack), 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(); check("t7_idle_after_rst", 64'(busy), 0);
    cyc(); check("t7_first_grant", 64'(grant), 2'b01);
    wait_done("t7_done");

    repeat (3) cyc();
    check("sb_drain", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs32_bus_arb.md
Name: hs32_bus_arb

Overview:
Round-robin arbiter that shares the single internal memory bus between N requesters. The requesters are the CPU core, the Caravel Wishbone host, and future DMA engines. The downstream side is the bus interconnect, which serves SRAM, MMIO and the external bus. It replaces the static bus_hold multiplexer with per-transaction arbitration, an eligibility mask, and a watchdog that terminates transactions nobody acknowledges.

Parameters:
N, 2, number of requesters; index 0 = CPU, index 1 = Wishbone host.
AW, 32, address width.
DW, 32, data width.
TIMEOUT, 64, cycles in BUSY without s_ack before forced termination; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m_stb  in  N  per-requester request, level, held until its ack
m_rw  in  N  per-requester write enable (1 = write)
m_addr  in  N*AW  per-requester address; requester i occupies bits [i*AW +: AW]
m_dtw  in  N*DW  per-requester write data, same packing as m_addr
m_ack  out  N  per-requester acknowledge, one-cycle pulse
m_err  out  1  pulses together with m_ack when the watchdog terminated the transaction
m_dtr  out  DW  read data, broadcast to all requesters; valid only while that requester's m_ack is high
eligible  in  N  eligibility mask; 0 = requester cannot win arbitration
s_stb  out  1  downstream request
s_rw  out  1  downstream write enable
s_addr  out  AW  downstream address
s_dtw  out  DW  downstream write data
s_ack  in  1  downstream acknowledge
s_dtr  in  DW  downstream read data
grant  out  N  one-hot owner of the bus; all zero when IDLE
busy  out  1  high in BUSY state

Behaviour:
- State machine has two states, IDLE and BUSY.
- Registers: state, grant_idx, last_idx, wd_cnt.
- Reset values: state=IDLE, grant=0, last_idx=N-1 (so requester 0 wins first), wd_cnt=0. Outputs during and after reset: s_stb=0, m_ack=0, m_err=0, busy=0.
- IDLE:
  - Compute req = m_stb & eligible.
  - If req is nonzero, select the first set bit scanning last_idx+1, last_idx+2, ... modulo N. Register it as grant_idx and go to BUSY.
  - If req is zero, stay in IDLE.
- BUSY, combinational outputs:
  - s_stb = m_stb[grant_idx].
  - s_rw, s_addr and s_dtw come from requester grant_idx.
  - m_ack[grant_idx] = s_ack; all other m_ack bits are 0.
  - m_dtr = s_dtr, passed straight through.
- Latency: a request sampled at edge k drives s_stb during cycle k+1. With a slave that acks in the same cycle, m_ack is high in cycle k+1.
- BUSY exits:
  - s_ack=1 → IDLE; last_idx <= grant_idx. There is exactly one idle bubble between transactions.
  - Granted requester drops m_stb before ack (abort) → IDLE the next cycle. s_stb falls with m_stb. No m_ack. last_idx <= grant_idx.
  - Watchdog: wd_cnt increments every BUSY cycle without s_ack. If TIMEOUT≠0 and wd_cnt == TIMEOUT-1 with no s_ack, then in that cycle s_stb is forced to 0 and m_ack[grant_idx]=1 with m_err=1. m_dtr is driven 32'hDEAD_BEEF in that cycle. Next state IDLE; last_idx <= grant_idx.
  - s_ack and timeout in the same cycle: s_ack wins, m_err=0.
  - wd_cnt clears on entry to BUSY. Width is clog2(TIMEOUT+1).
- Eligibility is sampled only in IDLE. Clearing an eligible bit during BUSY does not pre-empt the owner.
- s_ack seen while in IDLE is ignored; no m_ack is generated.
- Reset during BUSY: next cycle is IDLE with all outputs at reset values. The in-flight transaction is dropped without ack.
- Fairness: with all N requesters continuously requesting, each is granted once every N transactions.

Test Plan:
- Single requester: CPU write, m_addr=0x0000_0010, m_dtw=0x1234_5678, slave acks on the first s_stb cycle → s_stb high exactly 1 cycle at edge+1; s_addr=0x10, s_dtw=0x12345678; m_ack[0] 1 cycle; m_err=0.
- Contention: both requesters held high for 4 transactions, slave acks immediately → grant sequence 0,1,0,1; each m_ack exactly once per grant; busy low for 1 cycle between transactions.
- Eligibility: eligible=2'b10, both requesting → only requester 1 is ever granted. Set eligible=2'b01 mid-transaction → requester 1 still gets its ack, then requester 0 is granted.
- Read data: requester 1 reads, slave returns s_dtr=0xCAFE_F00D after 3 wait cycles → m_ack[1] in the 4th BUSY cycle with m_dtr=0xCAFEF00D; m_ack[0] stays 0 throughout.
- Watchdog, TIMEOUT=8, slave never acks → after 8 BUSY cycles m_ack=1, m_err=1, m_dtr=0xDEADBEEF, s_stb low, then IDLE. With s_ack in cycle 8 instead → normal ack, m_err=0.
- Abort and reset: granted requester drops m_stb in BUSY cycle 2 → no m_ack and next cycle IDLE. Assert rst in BUSY → grant=0, s_stb=0, and the next arbitration grants requester 0 first.
